// File: rtl/cache_refill_ctrl.sv
// Refill / write-through engine between the 2-way cache controller and the 32x8 synchronous RAM.
// Optional `REFILL_PERF_CNT_EN adds saturating refill/write event counters.
module cache_refill_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_way,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        line_index,
  output logic [11:0]       line_data,
  output logic              line_wren_way0,
  output logic              line_wren_way1,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic              busy
`ifdef REFILL_PERF_CNT_EN
  ,
  output logic [15:0]       refill_count,
  output logic [15:0]       write_count
`endif
);

  if (RAM_LAT < 1 || RAM_LAT > 3 || ADDR_W < 5 || DATA_W != 8) begin : g_bad_param
    $error("cache_refill_ctrl: RAM_LAT must be 1..3, ADDR_W >= 5, DATA_W == 8");
  end

  typedef enum logic [2:0] {IDLE, RD_WAIT, FILL, WR, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        lat_cnt;
  logic              way_q;
  logic              line_we;
  logic [DATA_W-1:0] line_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      way_q     <= 1'b0;
      lat_cnt   <= '0;
      done_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        ram_addr  <= req_addr;
        ram_wdata <= req_wdata;
        way_q     <= req_way;
        lat_cnt   <= 2'(RAM_LAT - 1);
      end
      if (state == RD_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - 2'd1;
      if (state == FILL)
        done_data <= ram_rdata;
      if (state == WR)
        done_data <= ram_wdata;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    ram_wren   = 1'b0;
    line_we    = 1'b0;
    line_byte  = '0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = req_write ? WR : RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt == '0)
          state_next = FILL;
      end
      FILL: begin
        line_we    = 1'b1;
        line_byte  = ram_rdata;
        state_next = DONE;
      end
      WR: begin
        ram_wren   = 1'b1;
        line_we    = 1'b1;
        line_byte  = ram_wdata;
        state_next = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line is always written valid with lru cleared; the controller owns the sibling LRU bit.
  assign line_data      = line_we ? {1'b1, 1'b0, ram_addr[4:3], line_byte} : '0;
  assign line_index     = ram_addr[2:0];
  assign line_wren_way0 = line_we & ~way_q;
  assign line_wren_way1 = line_we & way_q;
  assign busy           = (state != IDLE);

`ifdef REFILL_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      refill_count <= '0;
      write_count  <= '0;
    end else begin
      if (state_next == FILL && state != FILL && refill_count != '1)
        refill_count <= refill_count + 16'd1;
      if (state_next == WR && state != WR && write_count != '1)
        write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: random reads/writes against a memory-array reference,
// plus a RAM_LAT=3 instance for the long-latency read and reset-during-RD_WAIT cases.
module tb_cache_refill_ctrl;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // main instance (RAM_LAT = 1)
  logic       reset, req_valid, req_ready, req_write, req_way, ram_wren;
  logic [4:0] req_addr, ram_addr;
  logic [7:0] req_wdata, ram_wdata, ram_rdata, done_data;
  logic [2:0] line_index;
  logic [11:0] line_data;
  logic       line_wren_way0, line_wren_way1, done_valid, busy;
  // second instance (RAM_LAT = 3)
  logic       reset_b, req_valid_b, req_ready_b, req_write_b, req_way_b, ram_wren_b;
  logic [4:0] req_addr_b, ram_addr_b;
  logic [7:0] req_wdata_b, ram_wdata_b, ram_rdata_b, done_data_b;
  logic [2:0] line_index_b;
  logic [11:0] line_data_b;
  logic       line_wren_way0_b, line_wren_way1_b, done_valid_b, busy_b;
`ifdef REFILL_PERF_CNT_EN
  logic [15:0] refill_count, write_count, refill_count_b, write_count_b;
`endif

  cache_refill_ctrl #(.ADDR_W(5), .DATA_W(8), .RAM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_way(req_way),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .line_index(line_index), .line_data(line_data), .line_wren_way0(line_wren_way0),
    .line_wren_way1(line_wren_way1), .done_valid(done_valid), .done_data(done_data), .busy(busy)
`ifdef REFILL_PERF_CNT_EN
    , .refill_count(refill_count), .write_count(write_count)
`endif
  );

  cache_refill_ctrl #(.ADDR_W(5), .DATA_W(8), .RAM_LAT(LAT3)) dut_b (
    .clock(clock), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_way(req_way_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b), .ram_rdata(ram_rdata_b),
    .line_index(line_index_b), .line_data(line_data_b), .line_wren_way0(line_wren_way0_b),
    .line_wren_way1(line_wren_way1_b), .done_valid(done_valid_b), .done_data(done_data_b),
    .busy(busy_b)
`ifdef REFILL_PERF_CNT_EN
    , .refill_count(refill_count_b), .write_count(write_count_b)
`endif
  );

  // external 32x8 synchronous RAM; contents loaded from init_mem while reset is high
  logic [7:0] init_mem [32];
  logic [7:0] mem [32];
  logic [7:0] rd_pipe [LAT];
  logic [7:0] rd3 [LAT3];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    rd3[0] <= mem[ram_addr_b];
    for (int i = 1; i < LAT3; i++) rd3[i] <= rd3[i-1];
  end
  assign ram_rdata   = rd_pipe[LAT-1];
  assign ram_rdata_b = rd3[LAT3-1];

  // reference model: memory image plus expected-response queue
  typedef struct {
    logic       write;
    logic [4:0] addr;
    logic [7:0] data;
    logic       way;
    int         acc;
  } exp_t;

  logic [7:0] ref_mem [32];
  exp_t q [$];
  int checks = 0, passes = 0;
  int cyc = 0;
  int last_done = -100;
  int exp_reads = 0, exp_writes = 0;
  bit mon_en = 1'b0;
  bit line_seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // monitor for the main instance
  always @(negedge clock) begin
    exp_t e;
    bit   eb;
    if (mon_en) begin
      eb = (q.size() > 0) && (cyc > q[0].acc);
      check(busy == eb, "busy", busy, eb);
      check(req_ready == !eb, "req_ready", req_ready, !eb);
      if (line_wren_way0 && line_wren_way1) check(1'b0, "strobe_excl", 2'b11, 0);
      if (line_wren_way0 || line_wren_way1) begin
        if (q.size() == 0) begin
          check(1'b0, "line_unexpected", {line_wren_way1, line_wren_way0}, 0);
        end else begin
          e = q[0];
          check(line_wren_way1 == e.way && line_wren_way0 == !e.way, "line_way",
                {line_wren_way1, line_wren_way0}, e.way ? 2 : 1);
          check(line_index == e.addr[2:0], "line_index", line_index, e.addr[2:0]);
          check(line_data == {1'b1, 1'b0, e.addr[4:3], e.data}, "line_data", line_data,
                {1'b1, 1'b0, e.addr[4:3], e.data});
          check(cyc - e.acc == (e.write ? 1 : LAT + 1), "line_latency", cyc - e.acc,
                e.write ? 1 : LAT + 1);
          check(ram_wren == e.write, "ram_wren", ram_wren, e.write);
          if (e.write) begin
            check(ram_addr == e.addr, "ram_addr", ram_addr, e.addr);
            check(ram_wdata == e.data, "ram_wdata", ram_wdata, e.data);
          end
          line_seen = 1'b1;
        end
      end else if (ram_wren) begin
        check(1'b0, "ram_wren_unexpected", 1, 0);
      end
      if (done_valid) begin
        if (q.size() == 0) begin
          check(1'b0, "done_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check(done_data == e.data, "done_data", done_data, e.data);
          check(cyc - e.acc == (e.write ? 2 : LAT + 2), "done_latency", cyc - e.acc,
                e.write ? 2 : LAT + 2);
          check(line_seen, "line_before_done", line_seen, 1);
          line_seen = 1'b0;
          last_done = cyc;
        end
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input bit w, input logic [4:0] a, input logic [7:0] d, input bit wy,
                       input bit held);
    int   n;
    exp_t ne;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_way   = wy;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check(1'b0, "accept_timeout", 0, 1);
    end else begin
      if (held) check(cyc == last_done + 1, "b2b_accept", cyc, last_done + 1);
      ne.write = w;
      ne.addr  = a;
      ne.way   = wy;
      ne.acc   = cyc;
      if (w) begin
        ne.data   = d;
        ref_mem[a] = d;
        exp_writes++;
      end else begin
        ne.data = ref_mem[a];
        exp_reads++;
      end
      q.push_back(ne);
    end
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         held;
    int         gap, n, acc3;
    logic [4:0] a;

    for (int i = 0; i < 32; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    init_mem[5'h1B] = 8'hA5;
    ref_mem[5'h1B]  = 8'hA5;

    reset = 1'b1; reset_b = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_way = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_way_b = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0; reset_b = 1'b0;

    check(busy == 1'b0, "rst_busy", busy, 0);
    check(req_ready == 1'b1, "rst_ready", req_ready, 1);
    check({line_wren_way0, line_wren_way1, ram_wren, done_valid} == 4'b0, "rst_strobes",
          {line_wren_way0, line_wren_way1, ram_wren, done_valid}, 0);
    check(ram_addr == '0 && ram_wdata == '0, "rst_ram_regs", {ram_addr, ram_wdata}, 0);
    check(line_data == '0 && line_index == '0, "rst_line", {line_index, line_data}, 0);
    check(done_data == '0, "rst_done_data", done_data, 0);
    mon_en = 1'b1;

    // directed: refill, write-through, read-back, issued back to back
    issue(1'b0, 5'h1B, 8'h00, 1'b1, 1'b0);
    issue(1'b1, 5'h05, 8'h3C, 1'b0, 1'b1);
    issue(1'b0, 5'h05, 8'h00, 1'b1, 1'b1);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);

    held = 1'b0;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)),
            held);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        req_valid = 1'b0;
        repeat (gap) @(negedge clock);
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(q.size() == 0, "drain", q.size(), 0);
`ifdef REFILL_PERF_CNT_EN
    check(refill_count == 16'(exp_reads), "refill_count", refill_count, exp_reads);
    check(write_count == 16'(exp_writes), "write_count", write_count, exp_writes);
`endif

    // RAM_LAT = 3 instance: full read latency
    a = 5'($urandom_range(0, 31));
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = a; req_way_b = 1'b0;
    acc3 = cyc;
    @(negedge clock);
    req_valid_b = 1'b0;
    n = 0;
    while (!done_valid_b && n < 20) begin
      check(ram_wren_b == 1'b0, "b_ram_wren_read", ram_wren_b, 0);
      @(negedge clock);
      n++;
    end
    check(done_valid_b, "b_done_seen", done_valid_b, 1);
    check(cyc - acc3 == LAT3 + 2, "b_done_latency", cyc - acc3, LAT3 + 2);
    check(done_data_b == ref_mem[a], "b_done_data", done_data_b, ref_mem[a]);
    @(negedge clock);

    // RAM_LAT = 3 instance: reset during RD_WAIT
    req_valid_b = 1'b1; req_addr_b = 5'($urandom_range(0, 31)); req_way_b = 1'b1;
    check(req_ready_b == 1'b1, "b_ready_idle", req_ready_b, 1);
    @(negedge clock);
    req_valid_b = 1'b0;
    check(busy_b == 1'b1, "b_busy_rdwait", busy_b, 1);
    reset_b = 1'b1;
    @(negedge clock);
    reset_b = 1'b0;
    check(busy_b == 1'b0 && req_ready_b == 1'b1, "b_after_reset", {busy_b, req_ready_b}, 2'b01);
    for (int i = 0; i < 8; i++) begin
      check({line_wren_way0_b, line_wren_way1_b, ram_wren_b, done_valid_b} == 4'b0,
            "b_no_strobe_after_reset",
            {line_wren_way0_b, line_wren_way1_b, ram_wren_b, done_valid_b}, 0);
      @(negedge clock);
    end
    check(busy_b == 1'b0 && req_ready_b == 1'b1, "b_idle_final", {busy_b, req_ready_b}, 2'b01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
